// File: rtl/multdiv_if.sv
// multdiv_if: start/operand/result bundle between the execute stage and the mult/div unit
interface multdiv_if #(parameter int WIDTH = 32);
  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  modport master (
    output ctrl_mult, ctrl_div, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );
  modport slave (
    input  ctrl_mult, ctrl_div, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed shift-add multiply and restoring divide, one bit per cycle
module multdiv_unit #(parameter int WIDTH = 32) (
  input  logic      clock,
  input  logic      aclr,
  multdiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, prod, term;
  logic [WIDTH-1:0]   mplier, dvsr, quo, rem, result, mag_a, mag_b;
  logic [WIDTH:0]     rem_sh, diff;
  logic               neg, exc, rdy, busy_q, last, b_zero;
  assign last   = cnt == CW'(WIDTH);
  assign b_zero = bus.data_operandB == '0;
  assign mag_a  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b  = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign term   = mplier[0] ? mcand : '0;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvsr};
  assign bus.data_result    = result;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = rdy;
  assign bus.busy           = busy_q;
  // state register
  always_ff @(posedge clock or negedge aclr)
    if (!aclr) state <= IDLE;
    else       state <= state_n;
  // next state: multiply wins a simultaneous start, a zero divisor skips straight to DONE
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.ctrl_mult ? MUL : !bus.ctrl_div ? IDLE : b_zero ? DONE : DIV;
      MUL:     state_n = last ? DONE : MUL;
      DIV:     state_n = last ? DONE : DIV;
      default: state_n = IDLE;
    endcase
  end
  // datapath: the multiplier's top bit carries negative weight, so the last step subtracts
  always_ff @(posedge clock or negedge aclr)
    if (!aclr) begin
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      dvsr   <= '0;
      quo    <= '0;
      rem    <= '0;
      neg    <= 1'b0;
      result <= '0;
      exc    <= 1'b0;
      rdy    <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= state_n == MUL || state_n == DIV;
      rdy    <= state_n == DONE;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.ctrl_mult) begin
            mcand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
            mplier <= bus.data_operandB;
            prod   <= '0;
          end else if (bus.ctrl_div && b_zero) begin
            result <= '0;
            exc    <= 1'b1;
          end else if (bus.ctrl_div) begin
            dvsr <= mag_b;
            quo  <= mag_a;
            rem  <= '0;
            neg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          end
        end
        MUL: begin
          if (last) begin
            result <= prod[WIDTH-1:0];
            exc    <= !(&prod[2*WIDTH-1:WIDTH-1] || !(|prod[2*WIDTH-1:WIDTH-1]));
          end else begin
            prod   <= cnt == CW'(WIDTH-1) ? prod - term : prod + term;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        DIV: begin
          if (last) begin
            result <= neg ? -quo : quo;
            exc    <= !neg && quo[WIDTH-1];
          end else begin
            rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
endmodule
